// File: rtl/mii_tx_framer_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and the nibble-wide CRC32 step.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mii_tx_framer_pkg;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam int          ETH_MIN_FRAME = 60;

    localparam logic [10:0] BYTE_CNT_MAX  = 11'd2047;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_DRAIN,
        S_IFG
    } state_t;

    // Reflected CRC32 advanced by one nibble; bit 0 of the nibble enters first.
    function automatic logic [31:0] crc32_nib_next(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'h0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d4.sv
// Nibble-wide reflected CRC32 register (Ethernet polynomial) with synchronous init and enable.
// Latency: o_crc reflects a nibble one clk after it is presented with i_en=1.
// Backpressure: none; i_en simply holds the register.
//
// Ports: clk/rst_n clock and sync active-low reset; i_init loads CRC32_INIT (wins over i_en);
//        i_en advances the CRC by i_nib; o_crc is the running (non-inverted) register.
module crc32_d4
    import mii_tx_framer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [3:0]  i_nib,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (!rst_n || i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= crc32_nib_next(r_crc, i_nib);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mii_tx_framer.sv
// Egress framer: FWFT byte FIFO -> 100 Mb/s MII nibbles with preamble/SFD, zero padding, FCS and IFG.
// Latency: tx_en rises 1 clk after a non-empty FIFO is seen in IDLE; one nibble per clk thereafter.
// Backpressure: pops one byte per 2 clk; an empty FIFO mid-frame aborts the frame (tx_er, drain to del).
//
// Ports: clk/rst_n            25 MHz MII tx clock, synchronous active-low reset
//        i_fifo_dout/del/empty FIFO head byte, end-of-frame flag on that byte, FIFO empty
//        o_fifo_rden          single-cycle pop of the head byte
//        o_mii_txd/tx_en/tx_er MII transmit nibble, enable, error
//        o_busy               high whenever the FSM is not IDLE
//        o_frame_done         pulse on the last FCS nibble
//        o_underrun           pulse on the nibble where the FIFO ran dry mid-frame
module mii_tx_framer
    import mii_tx_framer_pkg::*;
#(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
    parameter int IFG_NIBBLES     = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_fifo_dout,
    input  logic       i_fifo_del,
    input  logic       i_fifo_empty,
    output logic       o_fifo_rden,
    output logic [3:0] o_mii_txd,
    output logic       o_mii_tx_en,
    output logic       o_mii_tx_er,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_underrun
);

    // Number of 0x5 nibbles before the SFD nibble.
    localparam logic [7:0] PRE_NIBS = 8'(2 * PREAMBLE_BYTES + 1);
    localparam logic [7:0] IFG_END  = 8'(IFG_NIBBLES);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_odd;
    logic [3:0]  r_hi_nib;
    logic        r_del;
    logic [10:0] r_byte_cnt;
    logic        r_del_seen;
    logic        r_rden;
    logic [3:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_underrun;

    logic        w_crc_init;
    logic        w_crc_en;
    logic [3:0]  w_crc_nib;
    logic [31:0] w_crc;
    logic [31:0] w_fcs;

    // The CRC follows exactly the nibbles put on the wire in DATA and PAD.
    always_comb begin
        w_crc_en  = 1'b0;
        w_crc_nib = 4'h0;
        case (r_state)
            S_DATA: begin
                if (!r_odd) begin
                    w_crc_en  = !i_fifo_empty;
                    w_crc_nib = i_fifo_dout[3:0];
                end else begin
                    w_crc_en  = 1'b1;
                    w_crc_nib = r_hi_nib;
                end
            end
            S_PAD:   w_crc_en = 1'b1;
            default: ;
        endcase
    end

    // Held at init through the whole preamble so preamble/SFD never enter the CRC.
    assign w_crc_init = (r_state == S_PREAMBLE);
    assign w_fcs      = ~w_crc;

    crc32_d4 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_nib  (w_crc_nib),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_odd        <= 1'b0;
            r_hi_nib     <= '0;
            r_del        <= 1'b0;
            r_byte_cnt   <= '0;
            r_del_seen   <= 1'b0;
            r_rden       <= 1'b0;
            r_txd        <= '0;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_rden       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_fifo_empty) begin
                        r_state <= S_PREAMBLE;
                        r_cnt   <= 8'd1;
                        r_txd   <= PREAMBLE_NIB;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt < PRE_NIBS) begin
                        r_txd <= PREAMBLE_NIB;
                    end else begin
                        r_txd      <= SFD_NIB;
                        r_state    <= S_DATA;
                        r_odd      <= 1'b0;
                        r_byte_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (!r_odd) begin
                        if (i_fifo_empty) begin
                            r_state    <= S_DRAIN;
                            r_txd      <= 4'h0;
                            r_tx_er    <= 1'b1;
                            r_underrun <= 1'b1;
                            r_del_seen <= 1'b0;
                        end else begin
                            r_rden   <= 1'b1;
                            r_hi_nib <= i_fifo_dout[7:4];
                            r_del    <= i_fifo_del;
                            r_txd    <= i_fifo_dout[3:0];
                            r_odd    <= 1'b1;
                            if (r_byte_cnt != BYTE_CNT_MAX) begin
                                r_byte_cnt <= r_byte_cnt + 11'd1;
                            end
                        end
                    end else begin
                        r_txd <= r_hi_nib;
                        r_odd <= 1'b0;
                        if (r_del) begin
                            r_cnt   <= '0;
                            r_state <= (int'(r_byte_cnt) < MIN_FRAME_BYTES) ? S_PAD : S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    r_txd <= 4'h0;
                    r_odd <= ~r_odd;
                    if (!r_odd) begin
                        r_byte_cnt <= r_byte_cnt + 11'd1;
                    end else if (int'(r_byte_cnt) >= MIN_FRAME_BYTES) begin
                        r_state <= S_FCS;
                        r_cnt   <= '0;
                    end
                end
                S_FCS: begin
                    r_txd <= w_fcs[{r_cnt[2:0], 2'b00} +: 4];
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd7) begin
                        // IFG counting starts on the next edge, so tx_en stays up for this nibble.
                        r_frame_done <= 1'b1;
                        r_state      <= S_IFG;
                        r_cnt        <= '0;
                    end
                end
                S_DRAIN: begin
                    // r_rden high means a pop is still in flight; the head byte is stale until it lands.
                    if (r_del_seen && !r_rden) begin
                        r_state <= S_IFG;
                        r_txd   <= 4'h0;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                        r_cnt   <= 8'd1;
                    end else if (!r_del_seen && !r_rden && !i_fifo_empty) begin
                        r_rden     <= 1'b1;
                        r_del_seen <= i_fifo_del;
                    end
                end
                S_IFG: begin
                    r_txd   <= 4'h0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (r_cnt == IFG_END) begin
                        if (!i_fifo_empty) begin
                            r_state <= S_PREAMBLE;
                            r_cnt   <= 8'd1;
                            r_txd   <= PREAMBLE_NIB;
                            r_tx_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                end
            endcase
        end
    end

    assign o_fifo_rden  = r_rden;
    assign o_mii_txd    = r_txd;
    assign o_mii_tx_en  = r_tx_en;
    assign o_mii_tx_er  = r_tx_er;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: a default-parameter instance and a MIN_FRAME_BYTES=0 instance share one
// FWFT FIFO model; sel routes the FIFO to one of them while the other sees an empty FIFO.
// Nibbles are captured on the falling edge and checked against bench-computed expectations.
module tb_mii_tx_framer;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_n = 1'b0;
    logic sel   = 1'b0;

    // FWFT FIFO model, flushed by the same reset as the DUT.
    logic [8:0] mem [0:1023];
    int         wr = 0;
    int         rd = 0;
    logic [7:0] f_dout;
    logic       f_del;
    logic       f_empty;
    assign f_empty = (wr == rd);
    assign {f_del, f_dout} = mem[rd[9:0]];

    logic       a_empty, b_empty;
    assign a_empty = sel ? 1'b1 : f_empty;
    assign b_empty = sel ? f_empty : 1'b1;

    logic [9:0] a_out, b_out;
    logic       m_rden, m_en, m_er, m_busy, m_done, m_und;
    logic [3:0] m_txd;
    assign {m_rden, m_txd, m_en, m_er, m_busy, m_done, m_und} = sel ? b_out : a_out;

    mii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME_BYTES(60), .IFG_NIBBLES(24)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_dout(f_dout), .i_fifo_del(f_del), .i_fifo_empty(a_empty),
        .o_fifo_rden(a_out[9]), .o_mii_txd(a_out[8:5]), .o_mii_tx_en(a_out[4]),
        .o_mii_tx_er(a_out[3]), .o_busy(a_out[2]), .o_frame_done(a_out[1]), .o_underrun(a_out[0])
    );

    mii_tx_framer #(.PREAMBLE_BYTES(7), .MIN_FRAME_BYTES(0), .IFG_NIBBLES(24)) u_dut_nopad (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_dout(f_dout), .i_fifo_del(f_del), .i_fifo_empty(b_empty),
        .o_fifo_rden(b_out[9]), .o_mii_txd(b_out[8:5]), .o_mii_tx_en(b_out[4]),
        .o_mii_tx_er(b_out[3]), .o_busy(b_out[2]), .o_frame_done(b_out[1]), .o_underrun(b_out[0])
    );

    always @(posedge clk) begin
        if (!rst_n)      rd <= wr;
        else if (m_rden) rd <= rd + 1;
    end

    // ---------------- capture / scoreboard state ----------------
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] nibs[$];
    int         rise_cyc[$];
    int         done_cyc[$];
    int         cyc = 0;
    int         n_und, n_rden, n_er, n_er_bad, n_gap, n_viol = 0, und_pos;
    logic       prev_en = 1'b0;

    typedef struct {
        bit          sel;
        int          len;
        int          pat;
        int          exp_nibs;   // nibbles after the SFD, FCS included
        bit          chk_fcs;
        logic [31:0] exp_fcs;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic clear_cap();
        nibs.delete();
        rise_cyc.delete();
        done_cyc.delete();
        n_und = 0; n_rden = 0; n_er = 0; n_er_bad = 0; n_gap = 0; und_pos = -1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_rden && f_empty) n_viol++;
        if (m_und) begin n_und++; und_pos = nibs.size(); end
        if (m_en) nibs.push_back(m_txd);
        if (m_er) n_er++;
        if (m_er && !m_en) n_er_bad++;
        if (m_done) done_cyc.push_back(cyc);
        if (m_rden) n_rden++;
        if (m_busy && !m_en) n_gap++;
        if (m_en && !prev_en) rise_cyc.push_back(cyc);
        prev_en = m_en;
    endtask

    task automatic push(input logic [7:0] b, input logic d);
        mem[wr[9:0]] = {d, b};
        wr++;
    endtask

    function automatic logic [7:0] gen_byte(input int pat, input int i);
        case (pat)
            0:       gen_byte = (i < 6) ? 8'hFF : 8'(i * 7 + 1);
            1:       gen_byte = 8'(8'h31 + i);           // ASCII "123456789"
            default: gen_byte = 8'(i ^ 8'hA5);
        endcase
    endfunction

    // Bit-serial reflected CRC32, LSB of each nibble first.
    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [3:0] nib);
        logic fb;
        for (int b = 0; b < 4; b++) begin
            fb = c[0] ^ nib[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int          t;
        int          start;
        int          errs;
        int          ndata;
        logic [7:0]  eb;
        logic [63:0] pre;
        logic [31:0] crc;
        logic [31:0] fcs;
        clear_cap();
        sel = v.sel;
        for (int i = 0; i < v.len; i++) push(gen_byte(v.pat, i), (i == v.len - 1));
        start = cyc;
        t = 0;
        do begin step(); t++; end while (!(done_cyc.size() > 0 && !m_busy) && t < 3000);
        chk({tag, "_bound"}, 64'(t < 3000), 64'd1);
        chk({tag, "_latency"}, 64'(rise_cyc.size() > 0 ? rise_cyc[0] - start : -1), 64'd1);
        pre = '0;
        for (int i = 0; i < 16 && i < nibs.size(); i++) pre[4*i +: 4] = nibs[i];
        chk({tag, "_preamble"}, pre, 64'hD555_5555_5555_5555);
        chk({tag, "_nibs"}, 64'(nibs.size() - 16), 64'(v.exp_nibs));
        errs  = 0;
        ndata = (v.exp_nibs - 8) / 2;
        for (int i = 0; i < ndata; i++) begin
            eb = (i < v.len) ? gen_byte(v.pat, i) : 8'h00;
            if (17 + 2*i >= nibs.size()) errs++;
            else if (nibs[16 + 2*i] !== eb[3:0] || nibs[17 + 2*i] !== eb[7:4]) errs++;
        end
        chk({tag, "_data"}, 64'(errs), 64'd0);
        crc = 32'hFFFFFFFF;
        for (int i = 16; i < nibs.size(); i++) crc = crc_bits(crc, nibs[i]);
        chk({tag, "_residue"}, 64'(crc), 64'h0000_0000_DEBB_20E3);
        chk({tag, "_frame_done"}, 64'(done_cyc.size()), 64'd1);
        chk({tag, "_rden"}, 64'(n_rden), 64'(v.len));
        chk({tag, "_tx_er"}, 64'(n_er), 64'd0);
        chk({tag, "_ifg"}, 64'(n_gap), 64'd24);
        if (v.chk_fcs) begin
            fcs = '0;
            for (int k = 0; k < 8 && nibs.size() >= 8; k++) fcs[4*k +: 4] = nibs[nibs.size() - 8 + k];
            chk({tag, "_fcs"}, 64'(fcs), 64'(v.exp_fcs));
        end
    endtask

    initial begin
        int t;
        // sel, len, pattern, nibbles after SFD, check FCS, FCS value (low nibble first on wire)
        vecs[0] = '{1'b0, 64, 0, 136, 1'b0, 32'h0};          // broadcast DA, 64 bytes, no pad
        vecs[1] = '{1'b0, 14, 2, 128, 1'b0, 32'h0};          // header only -> 46 pad bytes
        vecs[2] = '{1'b1,  9, 1,  26, 1'b1, 32'hCBF43926};   // "123456789", no padding
        vecs[3] = '{1'b0, 60, 2, 128, 1'b0, 32'h0};          // exactly minimum length
        vecs[4] = '{1'b0, 59, 2, 128, 1'b0, 32'h0};          // one pad byte
        vecs[5] = '{1'b1,  1, 2,  10, 1'b0, 32'h0};          // single byte, no padding
        vecs[6] = '{1'b0, 61, 2, 130, 1'b0, 32'h0};          // one past minimum

        clear_cap();
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 64'(a_out), 64'd0);
        chk("reset_outputs_nopad", 64'(b_out), 64'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++) run_frame(vecs[v], $sformatf("vec%0d", v));
        sel = 1'b0;

        // Two 60-byte frames queued together.
        clear_cap();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 60; i++) push(gen_byte(2, i), (i == 59));
        t = 0;
        do begin step(); t++; end while (!(done_cyc.size() == 2 && !m_busy) && t < 4000);
        chk("b2b_done", 64'(done_cyc.size()), 64'd2);
        chk("b2b_rden", 64'(n_rden), 64'd120);
        chk("b2b_gap", 64'((rise_cyc.size() > 1 && done_cyc.size() > 0) ? rise_cyc[1] - done_cyc[0] - 1 : -1), 64'd24);
        chk("b2b_idle_busy", 64'(n_gap), 64'd48);
        chk("b2b_nibs", 64'(nibs.size()), 64'd288);

        // FIFO runs dry after byte 20, then the rest of the frame arrives.
        clear_cap();
        for (int i = 0; i < 20; i++) push(gen_byte(2, i), 1'b0);
        t = 0;
        while (n_und == 0 && t < 500) begin step(); t++; end
        for (int i = 20; i < 64; i++) push(gen_byte(2, i), (i == 63));
        t = 0;
        do begin step(); t++; end while (!(n_und > 0 && !m_busy) && t < 3000);
        chk("und_pulse", 64'(n_und), 64'd1);
        chk("und_position", 64'(und_pos), 64'd56);
        chk("und_tx_er_span", 64'(n_er), 64'(nibs.size() - und_pos));
        chk("und_tx_er_without_en", 64'(n_er_bad), 64'd0);
        chk("und_frame_done", 64'(done_cyc.size()), 64'd0);
        chk("und_rden", 64'(n_rden), 64'd64);
        chk("und_ifg", 64'(n_gap), 64'd24);
        chk("und_fifo_drained", 64'(f_empty), 64'd1);

        // Reset for one clk in the middle of DATA; the FIFO is reset with it.
        clear_cap();
        for (int i = 0; i < 64; i++) push(gen_byte(0, i), (i == 63));
        t = 0;
        while (nibs.size() < 30 && t < 200) begin step(); t++; end
        rst_n = 1'b0;
        step();
        chk("midrst_outputs", 64'(a_out), 64'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_idle", 64'(a_out), 64'd0);
        chk("midrst_fifo_empty", 64'(f_empty), 64'd1);
        run_frame(vecs[0], "post_rst");

        chk("rden_while_empty", 64'(n_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
